// File: rtl/ref_align_fifo_pkg.sv
// rtl/ref_align_fifo_pkg.sv - shared operation decode for the reference alignment FIFO
//
// Purpose: names the one operation the FIFO performs in a cycle, and decodes it
//          from the push/pop strobes and the current full/empty state.
// Contents:
//   opKind_t - one-hot-free enum of per-cycle operations
//   decodeOp - maps (push, pop, empty, full) onto an opKind_t
package ref_align_fifo_pkg;

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_PUSHPOP,
    OP_BYPASS,
    OP_OVERFLOW,
    OP_UNDERFLOW
  } opKind_t;

  // A simultaneous push and pop on an empty queue is a bypass, not an
  // underflow; on a full queue it is a legal exchange, not an overflow.
  function automatic opKind_t decodeOp(input logic push, input logic pop,
                                       input logic empty, input logic full);
    opKind_t op;
    op = OP_IDLE;
    if (push && pop)
      op = empty ? OP_BYPASS : OP_PUSHPOP;
    else if (push)
      op = full ? OP_OVERFLOW : OP_PUSH;
    else if (pop)
      op = empty ? OP_UNDERFLOW : OP_POP;
    return op;
  endfunction

endpackage

// File: rtl/ref_align_fifo_if.sv
// rtl/ref_align_fifo_if.sv - stimulus/result bus of the reference alignment FIFO
//
// Purpose: bundles the reference push, DUT result pop and aligned monitor outputs.
// Modports:
//   master - stimulus side: drives refValidIn/refIn/measValidIn/measIn, observes the rest
//   slave  - the FIFO: consumes the strobes and data, drives aligned outputs and status
interface ref_align_fifo_if #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 4
);

  logic                 refValidIn;
  logic [DATAWIDTH-1:0] refIn;
  logic                 measValidIn;
  logic [DATAWIDTH-1:0] measIn;
  logic [DATAWIDTH-1:0] measOut;
  logic [DATAWIDTH-1:0] refOut;
  logic                 validOut;
  logic [ADDRWIDTH:0]   countOut;
  logic                 fullOut;
  logic                 emptyOut;
  logic                 overflowOut;
  logic                 underflowOut;

  modport master (
    output refValidIn, refIn, measValidIn, measIn,
    input  measOut, refOut, validOut, countOut, fullOut, emptyOut,
           overflowOut, underflowOut
  );

  modport slave (
    input  refValidIn, refIn, measValidIn, measIn,
    output measOut, refOut, validOut, countOut, fullOut, emptyOut,
           overflowOut, underflowOut
  );

endinterface

// File: rtl/ref_fifo_mem.sv
// rtl/ref_fifo_mem.sv - reference storage register file
//
// Purpose: 2**ADDRWIDTH x DATAWIDTH storage, synchronous write, asynchronous read.
//          Not reset: stale entries are never visible because the pointers
//          and count are reset instead.
// Ports:
//   clkIn     - clock, writes on rising edge
//   wrEnIn    - write enable
//   wrAddrIn  - write address
//   wrDataIn  - write data
//   rdAddrIn  - read address
//   rdDataOut - read data (combinational from rdAddrIn)
module ref_fifo_mem #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 4
) (
  input  logic                 clkIn,
  input  logic                 wrEnIn,
  input  logic [ADDRWIDTH-1:0] wrAddrIn,
  input  logic [DATAWIDTH-1:0] wrDataIn,
  input  logic [ADDRWIDTH-1:0] rdAddrIn,
  output logic [DATAWIDTH-1:0] rdDataOut
);

  localparam int ENTRIES = 2 ** ADDRWIDTH;

  logic [DATAWIDTH-1:0] mem [ENTRIES];

  always_ff @(posedge clkIn) begin
    if (wrEnIn)
      mem[wrAddrIn] <= wrDataIn;
  end

  assign rdDataOut = mem[rdAddrIn];

endmodule

// File: rtl/ref_align_fifo.sv
// rtl/ref_align_fifo.sv - aligns DUT results with queued expected values
//
// Purpose: queues expected results in issue order and, on each DUT result,
//          presents the result and its matching reference with a one-cycle
//          compare strobe. Flags ordering faults with sticky overflow/underflow.
// Ports:
//   clkIn - clock, all logic on rising edge
//   rstIn - synchronous active-high reset
//   bus   - ref_align_fifo_if.slave:
//           refValidIn/refIn   push an expected value
//           measValidIn/measIn DUT result, pops one reference
//           measOut/refOut     registered aligned pair
//           validOut           registered compare strobe
//           countOut           occupancy 0..DEPTH
//           fullOut/emptyOut   combinational from occupancy
//           overflowOut        sticky: push into full queue without pop
//           underflowOut       sticky: pop with nothing to pop
module ref_align_fifo
  import ref_align_fifo_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 4,
  parameter int DEPTH     = 16
) (
  input  logic clkIn,
  input  logic rstIn,
  ref_align_fifo_if.slave bus
);

  logic [ADDRWIDTH-1:0] wrPtr;
  logic [ADDRWIDTH-1:0] rdPtr;
  logic [ADDRWIDTH:0]   count;
  logic [DATAWIDTH-1:0] measReg;
  logic [DATAWIDTH-1:0] refReg;
  logic                 validReg;
  logic                 overflowReg;
  logic                 underflowReg;
  logic [DATAWIDTH-1:0] memRdData;

  logic    full;
  logic    empty;
  logic    refX;
  logic    measX;
  logic    pushReq;
  logic    popReq;
  logic    doPush;
  logic    doPop;
  opKind_t op;

  assign full  = (count == (ADDRWIDTH+1)'(DEPTH));
  assign empty = (count == '0);

  // An unknown strobe is an ordering fault in its own right; it must not
  // move pointers, so it is treated as inactive for the decode.
  assign refX    = $isunknown(bus.refValidIn);
  assign measX   = $isunknown(bus.measValidIn);
  assign pushReq = refX  ? 1'b0 : bus.refValidIn;
  assign popReq  = measX ? 1'b0 : bus.measValidIn;

  assign op     = decodeOp(pushReq, popReq, empty, full);
  assign doPush = (op == OP_PUSH) || (op == OP_PUSHPOP);
  assign doPop  = (op == OP_POP)  || (op == OP_PUSHPOP);

  ref_fifo_mem #(
    .DATAWIDTH(DATAWIDTH),
    .ADDRWIDTH(ADDRWIDTH)
  ) uMem (
    .clkIn    (clkIn),
    .wrEnIn   (doPush),
    .wrAddrIn (wrPtr),
    .wrDataIn (bus.refIn),
    .rdAddrIn (rdPtr),
    .rdDataOut(memRdData)
  );

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      wrPtr        <= '0;
      rdPtr        <= '0;
      count        <= '0;
      measReg      <= '0;
      refReg       <= '0;
      validReg     <= 1'b0;
      overflowReg  <= 1'b0;
      underflowReg <= 1'b0;
    end else begin
      validReg <= 1'b0;

      if (doPush)
        wrPtr <= wrPtr + 1'b1;
      if (doPop)
        rdPtr <= rdPtr + 1'b1;

      if (op == OP_PUSH)
        count <= count + (ADDRWIDTH+1)'(1);
      else if (op == OP_POP)
        count <= count - (ADDRWIDTH+1)'(1);

      if (doPop) begin
        refReg   <= memRdData;
        measReg  <= bus.measIn;
        validReg <= 1'b1;
      end else if (op == OP_BYPASS) begin
        refReg   <= bus.refIn;
        measReg  <= bus.measIn;
        validReg <= 1'b1;
      end

      if (op == OP_OVERFLOW || refX)
        overflowReg <= 1'b1;
      if (op == OP_UNDERFLOW || measX)
        underflowReg <= 1'b1;

      if (op == OP_OVERFLOW)
        $warning("ref_align_fifo overflow at %0t: refIn=%h dropped", $realtime, bus.refIn);
      if (op == OP_UNDERFLOW)
        $warning("ref_align_fifo underflow at %0t: measIn=%h has no reference", $realtime, bus.measIn);
      if (refX)
        $warning("ref_align_fifo unknown refValidIn at %0t", $realtime);
      if (measX)
        $warning("ref_align_fifo unknown measValidIn at %0t", $realtime);
    end
  end

  assign bus.measOut      = measReg;
  assign bus.refOut       = refReg;
  assign bus.validOut     = validReg;
  assign bus.countOut     = count;
  assign bus.fullOut      = full;
  assign bus.emptyOut     = empty;
  assign bus.overflowOut  = overflowReg;
  assign bus.underflowOut = underflowReg;

endmodule

// File: tb/tb_ref_align_fifo.sv
// tb/tb_ref_align_fifo.sv - directed self-checking bench for ref_align_fifo
module tb_ref_align_fifo;

  localparam int DATAWIDTH = 32;
  localparam int ADDRWIDTH = 4;
  localparam int DEPTH     = 16;

  logic clkIn;
  logic rstIn;

  int checkCount;
  int failCount;

  ref_align_fifo_if #(.DATAWIDTH(DATAWIDTH), .ADDRWIDTH(ADDRWIDTH)) bus ();

  ref_align_fifo #(
    .DATAWIDTH(DATAWIDTH),
    .ADDRWIDTH(ADDRWIDTH),
    .DEPTH    (DEPTH)
  ) dut (
    .clkIn(clkIn),
    .rstIn(rstIn),
    .bus  (bus)
  );

  initial clkIn = 1'b0;
  always #5 clkIn = ~clkIn;

  task automatic checkValue(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic stepCycle();
    @(posedge clkIn);
    #1;
  endtask

  task automatic idleInputs();
    bus.refValidIn  = 1'b0;
    bus.measValidIn = 1'b0;
  endtask

  task automatic doReset();
    idleInputs();
    rstIn = 1'b1;
    stepCycle();
    rstIn = 1'b0;
  endtask

  task automatic pushOne(input logic [31:0] value);
    bus.refValidIn  = 1'b1;
    bus.refIn       = value;
    bus.measValidIn = 1'b0;
    stepCycle();
    bus.refValidIn  = 1'b0;
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    bus.refIn  = '0;
    bus.measIn = '0;
    idleInputs();
    rstIn = 1'b1;
    stepCycle();
    stepCycle();
    rstIn = 1'b0;

    // Reset state
    checkValue("rst_count",     32'(bus.countOut), 32'd0);
    checkValue("rst_valid",     32'(bus.validOut), 32'd0);
    checkValue("rst_empty",     32'(bus.emptyOut), 32'd1);
    checkValue("rst_full",      32'(bus.fullOut), 32'd0);
    checkValue("rst_overflow",  32'(bus.overflowOut), 32'd0);
    checkValue("rst_underflow", 32'(bus.underflowOut), 32'd0);
    checkValue("rst_measOut",   bus.measOut, 32'd0);
    checkValue("rst_refOut",    bus.refOut, 32'd0);

    // Push 10,20,30 then pop with 10,20,31
    pushOne(32'd10);
    pushOne(32'd20);
    pushOne(32'd30);
    checkValue("t1_count3", 32'(bus.countOut), 32'd3);

    bus.measValidIn = 1'b1;
    bus.measIn = 32'd10;
    stepCycle();
    checkValue("t1_valid1", 32'(bus.validOut), 32'd1);
    checkValue("t1_ref1",   bus.refOut, 32'd10);
    checkValue("t1_meas1",  bus.measOut, 32'd10);
    bus.measIn = 32'd20;
    stepCycle();
    checkValue("t1_valid2", 32'(bus.validOut), 32'd1);
    checkValue("t1_ref2",   bus.refOut, 32'd20);
    checkValue("t1_meas2",  bus.measOut, 32'd20);
    bus.measIn = 32'd31;
    stepCycle();
    checkValue("t1_valid3", 32'(bus.validOut), 32'd1);
    checkValue("t1_ref3",   bus.refOut, 32'd30);
    checkValue("t1_meas3",  bus.measOut, 32'd31);
    checkValue("t1_differ3", 32'(bus.refOut != bus.measOut), 32'd1);
    bus.measValidIn = 1'b0;
    stepCycle();
    checkValue("t1_valid_end", 32'(bus.validOut), 32'd0);
    checkValue("t1_count_end", 32'(bus.countOut), 32'd0);
    checkValue("t1_hold_meas", bus.measOut, 32'd31);

    // Bypass on an empty queue
    bus.refValidIn  = 1'b1;
    bus.refIn       = 32'h55;
    bus.measValidIn = 1'b1;
    bus.measIn      = 32'h55;
    stepCycle();
    idleInputs();
    checkValue("byp_valid",     32'(bus.validOut), 32'd1);
    checkValue("byp_ref",       bus.refOut, 32'h55);
    checkValue("byp_meas",      bus.measOut, 32'h55);
    checkValue("byp_count",     32'(bus.countOut), 32'd0);
    checkValue("byp_overflow",  32'(bus.overflowOut), 32'd0);
    checkValue("byp_underflow", 32'(bus.underflowOut), 32'd0);
    stepCycle();
    checkValue("byp_pulse_end", 32'(bus.validOut), 32'd0);

    // Push 17 with no pops, then pop 16
    for (int i = 1; i <= 17; i++) begin
      pushOne(32'(i));
      if (i == 16)
        checkValue("ovf_none_at16", 32'(bus.overflowOut), 32'd0);
    end
    checkValue("ovf_count", 32'(bus.countOut), 32'd16);
    checkValue("ovf_full",  32'(bus.fullOut), 32'd1);
    checkValue("ovf_flag",  32'(bus.overflowOut), 32'd1);
    bus.measValidIn = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      bus.measIn = 32'(i);
      stepCycle();
      checkValue($sformatf("ovf_pop%0d_ref", i), bus.refOut, 32'(i));
      checkValue($sformatf("ovf_pop%0d_valid", i), 32'(bus.validOut), 32'd1);
    end
    bus.measValidIn = 1'b0;
    stepCycle();
    checkValue("ovf_drain_count", 32'(bus.countOut), 32'd0);
    checkValue("ovf_drain_empty", 32'(bus.emptyOut), 32'd1);

    // Underflow: pop on empty, no push
    bus.measValidIn = 1'b1;
    bus.measIn = 32'h1234;
    stepCycle();
    bus.measValidIn = 1'b0;
    checkValue("unf_flag",     32'(bus.underflowOut), 32'd1);
    checkValue("unf_valid",    32'(bus.validOut), 32'd0);
    checkValue("unf_hold_ref", bus.refOut, 32'd16);
    checkValue("unf_hold_meas", bus.measOut, 32'd16);
    checkValue("unf_count",    32'(bus.countOut), 32'd0);
    stepCycle();
    checkValue("unf_sticky",   32'(bus.underflowOut), 32'd1);

    // Full queue: push and pop together
    doReset();
    for (int i = 1; i <= 16; i++)
      pushOne(32'h100 + 32'(i));
    checkValue("pp_full", 32'(bus.fullOut), 32'd1);
    bus.refValidIn  = 1'b1;
    bus.refIn       = 32'h200;
    bus.measValidIn = 1'b1;
    bus.measIn      = 32'h101;
    stepCycle();
    idleInputs();
    checkValue("pp_ref",      bus.refOut, 32'h101);
    checkValue("pp_valid",    32'(bus.validOut), 32'd1);
    checkValue("pp_count",    32'(bus.countOut), 32'd16);
    checkValue("pp_overflow", 32'(bus.overflowOut), 32'd0);
    bus.measValidIn = 1'b1;
    bus.measIn = 32'h102;
    stepCycle();
    bus.measValidIn = 1'b0;
    checkValue("pp_next_ref", bus.refOut, 32'h102);
    checkValue("pp_next_count", 32'(bus.countOut), 32'd15);

    // Reset mid-stream drops pending references
    doReset();
    for (int i = 0; i < 5; i++)
      pushOne(32'h40 + 32'(i));
    rstIn = 1'b1;
    stepCycle();
    rstIn = 1'b0;
    checkValue("mr_count_rst", 32'(bus.countOut), 32'd0);
    pushOne(32'hAA);
    bus.measValidIn = 1'b1;
    bus.measIn = 32'hAA;
    stepCycle();
    bus.measValidIn = 1'b0;
    checkValue("mr_ref",       bus.refOut, 32'hAA);
    checkValue("mr_valid",     32'(bus.validOut), 32'd1);
    checkValue("mr_count",     32'(bus.countOut), 32'd0);
    checkValue("mr_overflow",  32'(bus.overflowOut), 32'd0);
    checkValue("mr_underflow", 32'(bus.underflowOut), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
